// File: rtl/node_mem_pkg.sv
// rtl/node_mem_pkg.sv - shared widths, FSM states and read-command type for the node memory responder
package node_mem_pkg;

  localparam int NODE_DATA_W  = 16;
  localparam int NODE_ADDR_W  = 26;
  localparam int NODE_BURST_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
  } node_state_t;

  typedef struct packed {
    logic [NODE_ADDR_W-1:0]  addr;
    logic [NODE_BURST_W-1:0] count;
  } node_rd_cmd_t;

  // A zero burstcount is serviced as a single beat.
  function automatic logic [NODE_BURST_W-1:0] eff_count(input logic [NODE_BURST_W-1:0] c);
    return (c == '0) ? NODE_BURST_W'(1) : c;
  endfunction

endpackage

// File: rtl/node_cmd_fifo.sv
// rtl/node_cmd_fifo.sv - pending read-command FIFO; push accepted on a full FIFO when popping the same cycle
module node_cmd_fifo
  import node_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  node_rd_cmd_t           push_data,
  input  logic                   pop,
  output node_rd_cmd_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);

  node_rd_cmd_t   store [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (level == (PW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign head    = store[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Entry storage needs no reset; occupancy decides what is live
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/node_mem_responder.sv
// rtl/node_mem_responder.sv - Avalon-MM burst slave node RAM with pipelined reads; NODE_STALL_EN adds LFSR back-pressure
module node_mem_responder
  import node_mem_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int CMD_DEPTH = 4,
  parameter int RD_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NODE_ADDR_W-1:0]  avs_node_address,
  input  logic                    avs_node_read,
  input  logic                    avs_node_write,
  input  logic [NODE_DATA_W-1:0]  avs_node_writedata,
  input  logic [NODE_BURST_W-1:0] avs_node_burstcount,
  output logic                    avs_node_waitrequest,
  output logic [NODE_DATA_W-1:0]  avs_node_readdata,
  output logic                    avs_node_readdatavalid,
  output logic                    bad_burst
);

  localparam int LW = $clog2(CMD_DEPTH) + 1;

  node_state_t              state;
  node_state_t              state_next;
  logic [NODE_DATA_W-1:0]   mem [2**ADDR_W];

  node_rd_cmd_t             head;
  node_rd_cmd_t             push_cmd;
  logic                     q_full;
  logic                     q_empty;
  logic [LW-1:0]            q_level;

  logic [NODE_BURST_W-1:0]  beat_idx;
  logic [ADDR_W-1:0]        wr_addr;
  logic [NODE_BURST_W-1:0]  wr_rem;
  logic [NODE_DATA_W-1:0]   rd_data [RD_LAT];
  logic [RD_LAT-1:0]        rd_valid;

  logic                     stall;
  logic                     pipe_busy;
  logic                     wr_ok;
  logic                     rd_ok;
  logic                     wr_acc;
  logic                     wr_first;
  logic                     rd_acc;
  logic                     issue;
  logic                     issue_last;
  logic [ADDR_W-1:0]        issue_addr;
  logic [ADDR_W-1:0]        ram_waddr;
  logic [NODE_BURST_W-1:0]  req_count;
  logic                     unused_addr_bits;

`ifdef NODE_STALL_EN
  logic [15:0] lfsr;

  // Free-running x^16+x^14+x^13+x^11+1 LFSR; low bits pick forced-stall cycles
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Writes may only start once every earlier read beat has left the pipeline
  assign pipe_busy = |rd_valid;
  assign req_count = eff_count(avs_node_burstcount);
  assign wr_ok     = (state == ST_WR) || ((state == ST_IDLE) && q_empty && !pipe_busy);
  assign rd_ok     = (state != ST_WR) && !q_full;

  // A concurrent write takes priority, so read back-pressure only applies without one
  assign avs_node_waitrequest = reset
                             || (avs_node_write && (!wr_ok || stall))
                             || (!avs_node_write && avs_node_read && (!rd_ok || stall));

  assign wr_acc   = avs_node_write && !avs_node_waitrequest;
  assign wr_first = wr_acc && (state == ST_IDLE);
  assign rd_acc   = avs_node_read && !avs_node_write && !avs_node_waitrequest;

  assign push_cmd = '{addr: NODE_ADDR_W'(avs_node_address[ADDR_W-1:0]), count: req_count};

  assign issue      = (state == ST_RD) && !q_empty && !stall;
  assign issue_last = issue && (beat_idx == (head.count - NODE_BURST_W'(1)));
  assign issue_addr = head.addr[ADDR_W-1:0] + ADDR_W'(beat_idx);
  assign ram_waddr  = wr_first ? avs_node_address[ADDR_W-1:0] : wr_addr;

  assign unused_addr_bits = &{1'b0, avs_node_address[NODE_ADDR_W-1:ADDR_W],
                              head.addr[NODE_ADDR_W-1:ADDR_W]};

  node_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_acc),
    .push_data (push_cmd),
    .pop       (issue_last),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .level     (q_level)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next state: the head entry keeps RD alive until its last beat issues
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (wr_first && (req_count > NODE_BURST_W'(1))) state_next = ST_WR;
        else if (rd_acc || !q_empty)                     state_next = ST_RD;
      end
      ST_RD: begin
        if (!rd_acc && ((issue_last && (q_level == LW'(1))) || q_empty))
          state_next = ST_IDLE;
      end
      ST_WR: begin
        if (wr_acc && (wr_rem == NODE_BURST_W'(1))) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Beat position in the head read burst, write-burst address/remaining, sticky bad_burst
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_idx  <= '0;
      wr_addr   <= '0;
      wr_rem    <= '0;
      bad_burst <= 1'b0;
    end else begin
      if (issue) beat_idx <= issue_last ? '0 : beat_idx + NODE_BURST_W'(1);
      if (wr_first) begin
        wr_addr <= avs_node_address[ADDR_W-1:0] + ADDR_W'(1);
        wr_rem  <= req_count - NODE_BURST_W'(1);
      end else if (wr_acc) begin
        wr_addr <= wr_addr + ADDR_W'(1);
        wr_rem  <= wr_rem - NODE_BURST_W'(1);
      end
      if ((wr_first || rd_acc) && (avs_node_burstcount == '0)) bad_burst <= 1'b1;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[ram_waddr] <= avs_node_writedata;
  end

  // Registered RAM read followed by RD_LAT-1 delay stages
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) rd_data[i] <= '0;
      rd_valid <= '0;
    end else begin
      rd_valid[0] <= issue;
      if (issue) rd_data[0] <= mem[issue_addr];
      for (int i = 1; i < RD_LAT; i++) begin
        rd_valid[i] <= rd_valid[i-1];
        rd_data[i]  <= rd_data[i-1];
      end
    end
  end

  assign avs_node_readdata      = rd_data[RD_LAT-1];
  assign avs_node_readdatavalid = rd_valid[RD_LAT-1];

endmodule

// File: tb/tb_node_mem_responder.sv
// tb/tb_node_mem_responder.sv - self-checking bench for node_mem_responder against a word-array memory model
module tb_node_mem_responder;

  localparam int ADDR_W    = 10;
  localparam int CMD_DEPTH = 4;
  localparam int RD_LAT    = 1;
  localparam int N         = 1 << ADDR_W;
  localparam int MASK      = N - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] address;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic [5:0]  burstcount;
  logic        waitrequest;
  logic [15:0] readdata;
  logic        readdatavalid;
  logic        bad_burst;

  node_mem_responder #(.ADDR_W(ADDR_W), .CMD_DEPTH(CMD_DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .avs_node_address       (address),
    .avs_node_read          (read),
    .avs_node_write         (write),
    .avs_node_writedata     (writedata),
    .avs_node_burstcount    (burstcount),
    .avs_node_waitrequest   (waitrequest),
    .avs_node_readdata      (readdata),
    .avs_node_readdatavalid (readdatavalid),
    .bad_burst              (bad_burst)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          beats_rx = 0;
  int          last_acc_cyc = 0;
  logic [15:0] mdl [N];
  logic [15:0] exp_q [$];
  int          vcyc [$];

  typedef struct {
    bit wr;
    int addr;
    int count;
    int exp_beats;
    bit exp_bad;
  } vec_t;
  vec_t vecs [9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every returned beat is matched in order against the model's expected words
  always @(negedge clk) begin
    if (readdatavalid === 1'b1) begin
      beats_rx++;
      vcyc.push_back(cyc);
      if (exp_q.size() == 0) chk("spurious_beat", readdatavalid, 1'b0);
      else                   chk("rd_data", readdata, exp_q.pop_front());
    end
  end

  task automatic do_read(input int a, input int c, output int waits);
    int n;
    n = (c == 0) ? 1 : c;
    waits = 0;
    address = 26'(a); burstcount = 6'(c); read = 1'b1;
    forever begin
      @(negedge clk);
      if (waitrequest === 1'b0) break;
      waits++;
      if (waits > 600) break;
    end
    if (waitrequest !== 1'b0) chk("rd_accept_timeout", waitrequest, 1'b0);
    else begin
      last_acc_cyc = cyc;
      for (int k = 0; k < n; k++) exp_q.push_back(mdl[(a + k) & MASK]);
    end
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic do_write(input int a, input int c, input int dbase, output int waits);
    int n;
    int w;
    logic [15:0] d;
    n = (c == 0) ? 1 : c;
    waits = 0;
    for (int k = 0; k < n; k++) begin
      d = (dbase >= 0) ? 16'(dbase + k) : 16'($urandom);
      write = 1'b1; writedata = d;
      if (k == 0) begin address = 26'(a); burstcount = 6'(c); end
      else begin address = 26'($urandom); burstcount = 6'($urandom); end
      w = 0;
      forever begin
        @(negedge clk);
        if (waitrequest === 1'b0) break;
        w++;
        if (w > 600) break;
      end
      if (waitrequest !== 1'b0) chk("wr_accept_timeout", waitrequest, 1'b0);
      else begin
        mdl[(a + k) & MASK] = d;
        if (k == 0) last_acc_cyc = cyc;
      end
      if (k == 0) waits = w;
      @(posedge clk); #1;
    end
    write = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_all_beats", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; read = 1'b0; write = 1'b0;
    @(negedge clk);
    chk("rst_waitrequest", waitrequest, 1'b1);
    @(posedge clk); #1;
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_readdatavalid", readdatavalid, 1'b0);
    chk("rst_readdata", readdata, 16'h0);
    chk("rst_bad_burst", bad_burst, 1'b0);
    chk("rst_waitrequest_rel", waitrequest, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int w5;
    int b0;
    bit ok;
    bit seen_zero;

    reset = 1'b1; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; burstcount = '0;
    apply_reset();

    // Give every RAM word a known value
    for (int b = 0; b < N; b += 63) do_write(b, (N - b < 63) ? N - b : 63, -1, w);

    // Write A0..A3 at 0x10, read back, check command-to-data latency
    do_write('h10, 4, 'hA0, w);
    vcyc.delete();
    do_read('h10, 4, w);
    drain();
    chk("rd_beats_4", vcyc.size(), 4);
    chk("rd_latency", vcyc[0] - last_acc_cyc, 1 + RD_LAT);

    // Four queued bursts of 8 fill the queue; the fifth command stalls
    vcyc.delete();
    for (int i = 0; i < 4; i++) do_read('h100 + 8 * i, 8, w);
    do_read('h120, 8, w5);
    chk("q_full_stall", w5 > 0, 1'b1);
    drain();
    chk("queued_beats", vcyc.size(), 40);
    ok = 1'b1;
    for (int i = 1; i < vcyc.size(); i++) if (vcyc[i] != vcyc[i-1] + 1) ok = 1'b0;
    chk("queued_contiguous", ok, 1'b1);

    // Read straddling the top of the RAM wraps to word 0
    do_write(N - 2, 4, -1, w);
    b0 = beats_rx;
    do_read(N - 2, 4, w);
    drain();
    chk("wrap_beats", beats_rx - b0, 4);

    // Write attempted while a read burst is pending waits for its last beat
    vcyc.delete();
    do_read('h80, 8, w);
    do_write('h81, 1, 'h5A5A, w);
    chk("wr_blocked_by_rd", w > 0, 1'b1);
    chk("wr_after_last_beat", last_acc_cyc > vcyc[$], 1'b1);
    do_read('h81, 1, w);
    drain();

    // Table of read/write vectors with expected beat count and bad_burst
    vecs[0] = '{0, 'h20, 1, 1, 0};
    vecs[1] = '{1, 'h40, 5, 0, 0};
    vecs[2] = '{0, 'h40, 5, 5, 0};
    vecs[3] = '{0, 'h3FF, 2, 2, 0};
    vecs[4] = '{1, 'h3F0, 63, 0, 0};
    vecs[5] = '{0, 'h3F0, 63, 63, 0};
    vecs[6] = '{1, 'h12345, 3, 0, 0};
    vecs[7] = '{0, 'h345, 3, 3, 0};
    vecs[8] = '{0, 'h100, 0, 1, 1};
    for (int i = 0; i < 9; i++) begin
      b0 = beats_rx;
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].count, -1, w);
      else            do_read(vecs[i].addr, vecs[i].count, w);
      drain();
      chk($sformatf("vec%0d_beats", i), beats_rx - b0, vecs[i].exp_beats);
      chk($sformatf("vec%0d_bad", i), bad_burst, vecs[i].exp_bad);
    end

    // Burstcount 0: single beat, sticky bad_burst until reset
    apply_reset();
    b0 = beats_rx;
    do_read('h55, 0, w);
    drain();
    chk("zero_burst_beats", beats_rx - b0, 1);
    chk("zero_burst_bad", bad_burst, 1'b1);
    do_write('h60, 2, -1, w);
    do_read('h60, 2, w);
    drain();
    chk("bad_burst_sticky", bad_burst, 1'b1);
    apply_reset();

    // Randomized traffic checked by the memory model
    seen_zero = 1'b0;
    for (int i = 0; i < 80; i++) begin
      int a;
      int c;
      a = int'($urandom_range(0, (1 << 26) - 1));
      c = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      if (c == 0) seen_zero = 1'b1;
      if ($urandom_range(0, 1) == 1) do_write(a, c, -1, w);
      else                           do_read(a, c, w);
    end
    drain();
    chk("rand_bad_burst", bad_burst, seen_zero);

    // Reset in the middle of a read burst discards it but keeps RAM contents
    do_read('h200, 16, w);
    repeat (4) @(posedge clk);
    #1;
    apply_reset();
    repeat (20) @(posedge clk);
    #1;
    b0 = beats_rx;
    do_read('h300, 4, w);
    do_read('h200, 2, w);
    drain();
    chk("post_reset_beats", beats_rx - b0, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
